// File: rtl/ram_responder_pkg.sv
// Shared constants for the memory-side responder: IO window decode, register offsets and the
// status byte layout.
package ram_responder_pkg;

  localparam int unsigned IoSelHi = 17;
  localparam int unsigned IoSelLo = 16;
  localparam logic [1:0]  IoSelVal = 2'b11;

  localparam logic [2:0] IoDataOfs = 3'd0;
  localparam logic [2:0] IoStatOfs = 3'd4;

  localparam int unsigned StatEmptyBit = 0;
  localparam int unsigned StatPendBit  = 1;
  localparam int unsigned StatOvfBit   = 2;

  typedef enum logic [1:0] {
    AccRamWr,
    AccRamRd,
    AccIoWr,
    AccIoRd
  } acc_e;

  function automatic logic [7:0] status_byte(input logic ovf, input logic pend,
                                             input logic empty);
    logic [7:0] s;
    s = '0;
    s[StatOvfBit]   = ovf;
    s[StatPendBit]  = pend;
    s[StatEmptyBit] = empty;
    return s;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO for IO transmit paths. A push into a full FIFO is only taken when a pop frees a
// slot on the same edge.
module io_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            push,
  input  logic [7:0]      push_data,
  input  logic            pop,
  output logic [7:0]      head,
  output logic [CntW-1:0] count,
  output logic            empty,
  output logic            full
);

  logic [7:0]      data_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = data_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) data_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side target of the byte-serial RAM bus: byte RAM with registered read, plus an IO
// window feeding a TX FIFO and returning received bytes and status.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW      = 17,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] addr,
  input  logic        is_write,
  input  logic [7:0]  write,
  output logic [7:0]  read,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int unsigned     CntW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] FullThresh = CntW'(FIFO_DEPTH - FULL_MARGIN);

  logic [7:0] mem [2**RAM_AW];

  logic              is_io;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        io_ofs;
  acc_e              acc;
  logic              unused_addr;

  logic            ram_we, push_req, push_acc, tx_pop, rx_pop;
  logic [CntW-1:0] count, count_next;
  logic            fifo_empty, fifo_full;

  logic [7:0] read_d, read_q;
  logic       rx_pending_d, rx_pending_q;
  logic [7:0] rx_byte_q;
  logic       overflow_q;
  logic       iobf_q;

  assign is_io       = (addr[IoSelHi:IoSelLo] == IoSelVal);
  assign ram_idx     = addr[RAM_AW-1:0];
  assign io_ofs      = addr[2:0];
  assign unused_addr = ^addr;

  always_comb begin
    if (is_io) acc = is_write ? AccIoWr : AccIoRd;
    else       acc = is_write ? AccRamWr : AccRamRd;
  end

  always_comb begin
    ram_we   = 1'b0;
    push_req = 1'b0;
    rx_pop   = 1'b0;
    read_d   = read_q;
    if (rdy_in) begin
      unique case (acc)
        AccRamWr: ram_we = 1'b1;
        AccRamRd: read_d = mem[ram_idx];
        AccIoWr:  push_req = (io_ofs == IoDataOfs);
        AccIoRd: begin
          if (io_ofs == IoDataOfs) begin
            read_d = rx_byte_q;
            rx_pop = 1'b1;
          end else if (io_ofs == IoStatOfs) begin
            read_d = status_byte(overflow_q, rx_pending_q, fifo_empty);
          end else begin
            read_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  // A full FIFO still takes the byte if the sink drains one on the same edge.
  assign push_acc   = push_req && (!fifo_full || tx_pop);
  assign count_next = count + CntW'(push_acc) - CntW'(tx_pop);

  // A byte arriving on the pop edge is newer than the one being read, so it stays pending.
  assign rx_pending_d = rx_valid ? 1'b1 : (rx_pop ? 1'b0 : rx_pending_q);

  io_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (push_acc),
    .push_data (write),
    .pop       (tx_pop),
    .head      (tx_data),
    .count     (count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      read_q       <= '0;
      rx_pending_q <= 1'b0;
      rx_byte_q    <= '0;
      overflow_q   <= 1'b0;
      iobf_q       <= 1'b0;
    end else begin
      read_q       <= read_d;
      rx_pending_q <= rx_pending_d;
      if (rx_valid) rx_byte_q <= rx_data;
      if (push_req && !push_acc) overflow_q <= 1'b1;
      iobf_q       <= (count_next >= FullThresh);
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) mem[ram_idx] <= write;
  end

  assign read           = read_q;
  assign io_buffer_full = iobf_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: bus reads are scored against a queue of expected bytes, TX/RX and
// back-pressure are checked directly against values worked out here.
module tb_ram_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic [31:0] addr;
  logic        is_write;
  logic [7:0]  write;
  logic [7:0]  read;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int         total = 0;
  int         bad = 0;
  logic [7:0] rd_exp_q [$];
  logic [7:0] last_rd;

  ram_responder dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .addr           (addr),
    .is_write       (is_write),
    .write          (write),
    .read           (read),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One bus transfer; rdy_in is dropped again right after the edge so idle cycles do nothing.
  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d,
                     input logic rxv, input logic [7:0] rxd);
    logic [7:0] exp;
    @(negedge clk_in);
    rdy_in   = 1'b1;
    is_write = wr;
    addr     = a;
    write    = d;
    rx_valid = rxv;
    rx_data  = rxd;
    @(posedge clk_in);
    #1;
    rdy_in   = 1'b0;
    rx_valid = 1'b0;
    if (!wr) begin
      check_eq("sb_depth", rd_exp_q.size(), 1);
      if (rd_exp_q.size() > 0) begin
        exp = rd_exp_q.pop_front();
        check_eq("rd_data", read, exp);
        last_rd = exp;
      end
    end else begin
      check_eq("rd_hold_wr", read, last_rd);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    rd_exp_q.push_back(exp);
    bus(1'b0, a, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b0;
    addr     = '0;
    is_write = 1'b0;
    write    = '0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    last_rd  = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst_read", read, 0);
    check_eq("rst_iobf", io_buffer_full, 0);
    check_eq("rst_txv", tx_valid, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // RAM write/read, including the top of the array and an odd IO offset
    wr(32'h0001_0, 8'h5A);
    rd(32'h0001_0, 8'h5A);
    wr(32'h1FFFF, 8'hA5);
    wr(32'h00000, 8'hC3);
    rd(32'h00000, 8'hC3);
    rd(32'h1FFFF, 8'hA5);
    rd(32'h00010, 8'h5A);
    rd(32'h30002, 8'h00);

    // RX capture and pop
    @(negedge clk_in);
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
    rd(32'h30004, 8'h03);
    rd(32'h30000, 8'h33);
    rd(32'h30004, 8'h01);

    // New byte arriving on the pop edge stays pending
    @(negedge clk_in);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
    rd_exp_q.push_back(8'h77);
    bus(1'b0, 32'h30000, 8'h00, 1'b1, 8'h55);
    rd(32'h30004, 8'h03);
    rd(32'h30000, 8'h55);
    rd(32'h30004, 8'h01);

    // Single TX byte passes straight through
    tx_ready = 1'b1;
    wr(32'h30000, 8'h41);
    check_eq("tx1_valid", tx_valid, 1);
    check_eq("tx1_data", tx_data, 32'h41);
    @(posedge clk_in);
    #1;
    check_eq("tx1_drained", tx_valid, 0);
    wr(32'h30001, 8'h99);
    wr(32'h30004, 8'h98);
    check_eq("tx_ignored_ofs", tx_valid, 0);

    // Fill to the back-pressure threshold, then to full, then overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(32'h30000, 8'(8'h10 + i));
      check_eq("iobf_fill", io_buffer_full, 32'(i >= 5));
    end
    wr(32'h30000, 8'h16);
    wr(32'h30000, 8'h17);
    check_eq("iobf_full", io_buffer_full, 1);
    rd(32'h30004, 8'h00);
    wr(32'h30000, 8'h18);
    rd(32'h30004, 8'h04);

    // Push into a full FIFO on a pop edge is taken; then drain
    tx_ready = 1'b1;
    wr(32'h30000, 8'h19);
    check_eq("iobf_pushpop", io_buffer_full, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq("tx_head", tx_data, (i < 7) ? 32'(8'h11 + i) : 32'h19);
      @(posedge clk_in);
      #1;
      check_eq("iobf_drain", io_buffer_full, 32'((7 - i) >= 6));
    end
    check_eq("tx_empty", tx_valid, 0);
    rd(32'h30004, 8'h05);

    // rdy_in low: no RAM write, read holds, TX still drains
    tx_ready = 1'b0;
    wr(32'h30000, 8'h61);
    wr(32'h30000, 8'h62);
    @(negedge clk_in);
    rdy_in   = 1'b0;
    is_write = 1'b1;
    addr     = 32'h10;
    write    = 8'hFF;
    tx_ready = 1'b1;
    @(posedge clk_in);
    #1;
    check_eq("rdy0_read", read, last_rd);
    check_eq("rdy0_head", tx_data, 32'h62);
    @(posedge clk_in);
    #1;
    check_eq("rdy0_drained", tx_valid, 0);
    check_eq("rdy0_read2", read, last_rd);
    tx_ready = 1'b0;
    rd(32'h00010, 8'h5A);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 6; i++) wr(32'h30000, 8'(8'h70 + i));
    rd(32'h1FFFF, 8'hA5);
    @(negedge clk_in);
    tx_ready = 1'b1;
    #2;
    check_eq("pre_rst_iobf", io_buffer_full, 1);
    check_eq("pre_rst_txv", tx_valid, 1);
    rst_n_in = 1'b0;
    #1;
    check_eq("arst_txv", tx_valid, 0);
    check_eq("arst_iobf", io_buffer_full, 0);
    check_eq("arst_read", read, 0);
    last_rd = 8'h00;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tx_ready = 1'b0;
    rd(32'h30004, 8'h01);
    rd(32'h00010, 8'h5A);
    rd(32'h1FFFF, 8'hA5);
    rd(32'h00000, 8'hC3);

    check_eq("sb_left", rd_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
